// File: rtl/focus_sweep_sched_if.sv
// Purpose: bundles the focus scheduler's control, metric, VCM handshake and status signals.
// Latency: none, this is wiring only.
// Backpressure: the VCM write holds vcm_req/vcm_data until vcm_ack is seen.
//
// Signals:
//   auto_foc   start request (level; a rising edge starts a search)
//   abort      single-cycle cancel pulse
//   frame_end  single-cycle frame boundary; sharp is valid in the same cycle
//   sharp      24-bit unsigned sharpness of the frame just ended
//   vcm_ack    I2C writer accepted vcm_data
//   vcm_req    VCM write request
//   vcm_data   {2'b00, step, 4'b0000}
//   step       commanded lens position
//   best_step  best position found so far
//   best_sharp metric measured at best_step
//   busy       search in progress
//   done       set by a successful park, cleared by the next start or by reset
// Modports: master = the scheduler, slave = the surrounding sensor/I2C side.
interface focus_sweep_sched_if;
    logic        auto_foc;
    logic        abort;
    logic        frame_end;
    logic [23:0] sharp;
    logic        vcm_ack;
    logic        vcm_req;
    logic [15:0] vcm_data;
    logic [9:0]  step;
    logic [9:0]  best_step;
    logic [23:0] best_sharp;
    logic        busy;
    logic        done;

    modport master (
        input  auto_foc, abort, frame_end, sharp, vcm_ack,
        output vcm_req, vcm_data, step, best_step, best_sharp, busy, done
    );

    modport slave (
        output auto_foc, abort, frame_end, sharp, vcm_ack,
        input  vcm_req, vcm_data, step, best_step, best_sharp, busy, done
    );
endinterface

// File: rtl/focus_sweep_sched.sv
// Purpose: frame-synchronous autofocus that runs a coarse sweep, then a fine sweep, then parks the lens.
// Latency: 2 cycles from metric capture to the next vcm_req (MEASURE -> ADVANCE -> MOVE).
// Backpressure: each VCM write holds vcm_req/vcm_data stable until vcm_ack; an abort during a write waits for its ack.
//
// Ports:
//   video_clk  sole clock, rising edge
//   reset      synchronous, active-high
//   bus        focus_sweep_sched_if.master (metric in, VCM handshake, status out)
module focus_sweep_sched #(
    parameter int STEP_MIN      = 0,
    parameter int STEP_MAX      = 1020,
    parameter int COARSE_STEP   = 64,
    parameter int FINE_STEP     = 8,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic                   video_clk,
    input  logic                   reset,
    focus_sweep_sched_if.master    bus
);

    localparam logic [9:0]  MIN_STEP    = 10'(STEP_MIN);
    localparam logic [9:0]  MAX_STEP    = 10'(STEP_MAX);
    localparam logic [10:0] COARSE_INC  = 11'(COARSE_STEP);
    localparam logic [10:0] FINE_INC    = 11'(FINE_STEP);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE, MOVE, SETTLE, MEASURE, ADVANCE, FINE_INIT, PARK, PARK_WAIT
    } state_t;

    state_t      state;
    logic        phase_fine;
    logic        abort_lat;
    logic        auto_foc_q;
    logic [3:0]  settle_cnt;
    logic [9:0]  hi_r;
    logic [9:0]  step_r;
    logic [9:0]  best_step_r;
    logic [23:0] best_sharp_r;
    logic        vcm_req_r;
    logic [15:0] vcm_data_r;
    logic        busy_r;
    logic        done_r;

    logic        start;
    logic [10:0] adv_next;
    logic [10:0] adv_limit;
    logic signed [11:0] lo_diff;
    logic [10:0] hi_sum;
    logic [9:0]  fine_lo;
    logic [9:0]  fine_hi;

    function automatic logic [15:0] vcm_word(input logic [9:0] s);
        return {2'b00, s, 4'b0000};
    endfunction

    assign start = bus.auto_foc & ~auto_foc_q;

    // Next sweep point is formed in 11 bits so stepping past 1023 is seen as "beyond the limit".
    // The fine window is clamped to the searchable range; the low edge is signed so it cannot wrap.
    always_comb begin
        adv_next  = {1'b0, step_r} + (phase_fine ? FINE_INC : COARSE_INC);
        adv_limit = phase_fine ? {1'b0, hi_r} : {1'b0, MAX_STEP};
        lo_diff   = $signed({2'b00, best_step_r}) - $signed({1'b0, COARSE_INC});
        fine_lo   = (lo_diff < $signed({2'b00, MIN_STEP})) ? MIN_STEP : lo_diff[9:0];
        hi_sum    = {1'b0, best_step_r} + COARSE_INC;
        fine_hi   = (hi_sum > {1'b0, MAX_STEP}) ? MAX_STEP : hi_sum[9:0];
    end

    always_ff @(posedge video_clk) begin
        if (reset) begin
            state        <= IDLE;
            phase_fine   <= 1'b0;
            abort_lat    <= 1'b0;
            // Loading the live level means a request held through reset is not seen as an edge.
            auto_foc_q   <= bus.auto_foc;
            settle_cnt   <= '0;
            hi_r         <= '0;
            step_r       <= '0;
            best_step_r  <= '0;
            best_sharp_r <= '0;
            vcm_req_r    <= 1'b0;
            vcm_data_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            auto_foc_q <= bus.auto_foc;
            case (state)
                IDLE: begin
                    if (start) begin
                        done_r       <= 1'b0;
                        best_sharp_r <= '0;
                        best_step_r  <= '0;
                        step_r       <= MIN_STEP;
                        vcm_data_r   <= vcm_word(MIN_STEP);
                        vcm_req_r    <= 1'b1;
                        phase_fine   <= 1'b0;
                        abort_lat    <= 1'b0;
                        busy_r       <= 1'b1;
                        state        <= MOVE;
                    end
                end

                // Both write states keep the request up until ack; an abort is only remembered
                // here so the I2C writer never sees a withdrawn request.
                MOVE, PARK_WAIT: begin
                    if (bus.vcm_ack) begin
                        vcm_req_r <= 1'b0;
                        abort_lat <= 1'b0;
                        if (abort_lat || bus.abort) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b0;
                            state  <= IDLE;
                        end else if (state == MOVE) begin
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end
                    end else if (bus.abort) begin
                        abort_lat <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.frame_end) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                end

                MEASURE: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.frame_end) begin
                        // Strictly greater: on a tie the earlier position stays best.
                        if (bus.sharp > best_sharp_r) begin
                            best_sharp_r <= bus.sharp;
                            best_step_r  <= step_r;
                        end
                        state <= ADVANCE;
                    end
                end

                ADVANCE: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                        state  <= IDLE;
                    end else if (adv_next > adv_limit) begin
                        state <= phase_fine ? PARK : FINE_INIT;
                    end else begin
                        step_r     <= adv_next[9:0];
                        vcm_data_r <= vcm_word(adv_next[9:0]);
                        vcm_req_r  <= 1'b1;
                        state      <= MOVE;
                    end
                end

                // Best point is kept, so fine points must strictly beat the coarse winner.
                FINE_INIT: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        step_r     <= fine_lo;
                        hi_r       <= fine_hi;
                        phase_fine <= 1'b1;
                        vcm_data_r <= vcm_word(fine_lo);
                        vcm_req_r  <= 1'b1;
                        state      <= MOVE;
                    end
                end

                PARK: begin
                    step_r     <= best_step_r;
                    vcm_data_r <= vcm_word(best_step_r);
                    vcm_req_r  <= 1'b1;
                    if (bus.abort) begin
                        abort_lat <= 1'b1;
                    end
                    state <= PARK_WAIT;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vcm_req    = vcm_req_r;
    assign bus.vcm_data   = vcm_data_r;
    assign bus.step       = step_r;
    assign bus.best_step  = best_step_r;
    assign bus.best_sharp = best_sharp_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_focus_sweep_sched.sv
// Purpose: self-checking bench for focus_sweep_sched; expected VCM writes are queued, a monitor checks each handshake.
// Latency: n/a.
// Backpressure: the I2C responder acks after a programmable number of request cycles.
module tb_focus_sweep_sched;

    logic video_clk = 1'b0;
    logic reset;

    focus_sweep_sched_if bus();

    focus_sweep_sched dut (
        .video_clk (video_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 video_clk = ~video_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          hs_count = 0;
    int          frames_since_ack = 0;
    int          ack_delay = 1;
    int          mode = 0;
    bit          poison = 1'b0;
    bit          in_req = 1'b0;
    logic [15:0] first_data;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Lens response: mode 0 peaks at 300, mode 1 rises toward the top of the range.
    function automatic logic [23:0] lens_sharp(input logic [9:0] s);
        int d;
        if (mode == 0) begin
            d = int'(s) - 300;
            if (d < 0) d = -d;
            return 24'(1000 - d);
        end
        return {14'b0, s};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge video_clk);
            #1;
        end
    endtask

    task automatic push_range(input int lo, input int hi, input int st);
        for (int s = lo; s <= hi; s += st) exp_q.push_back(16'(s << 4));
    endtask

    task automatic push_peak300;
        push_range(0, 960, 64);
        push_range(256, 384, 8);
        exp_q.push_back(16'h1280);
    endtask

    task automatic start_search;
        bus.auto_foc = 1'b0;
        tick(2);
        bus.auto_foc = 1'b1;
        tick(1);
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!bus.done && n < 6000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_hs(input int target, input int limit);
        int n;
        n = 0;
        while (hs_count < target && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    // Monitor: sampled on the falling edge; a handshake completes on the following rising edge.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge video_clk);
            if (reset) begin
                in_req = 1'b0;
                frames_since_ack = 0;
            end else if (bus.vcm_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    first_data = bus.vcm_data;
                end
                if (bus.vcm_ack) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: got data %h, required no write", bus.vcm_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_data", bus.vcm_data, e);
                        check("write_stable", first_data, e);
                    end
                    in_req = 1'b0;
                    frames_since_ack = 0;
                end else if (bus.frame_end) begin
                    frames_since_ack++;
                end
            end else begin
                in_req = 1'b0;
                if (bus.frame_end) frames_since_ack++;
            end
        end
    end

    // Frame source: one frame every 4 cycles; with poison on, the settle frames carry all-ones.
    initial begin
        bus.frame_end = 1'b0;
        bus.sharp     = '0;
        forever begin
            tick(3);
            bus.sharp     = (poison && frames_since_ack < 2) ? 24'hFFFFFF : lens_sharp(bus.step);
            bus.frame_end = 1'b1;
            tick(1);
            bus.frame_end = 1'b0;
        end
    end

    // I2C writer model.
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        bus.vcm_ack = 1'b0;
        forever begin
            @(posedge video_clk);
            #1;
            bus.vcm_ack = 1'b0;
            if (bus.vcm_req && !reset) begin
                if (wait_cnt >= ack_delay) begin
                    bus.vcm_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        reset        = 1'b1;
        bus.auto_foc = 1'b0;
        bus.abort    = 1'b0;
        tick(3);
        check("rst_req",   bus.vcm_req, 0);
        check("rst_data",  bus.vcm_data, 0);
        check("rst_step",  bus.step, 0);
        check("rst_best",  bus.best_step, 0);
        check("rst_sharp", bus.best_sharp, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        reset = 1'b0;
        tick(2);

        // 1: default sweep, peak at 300, ack one cycle after request.
        base = hs_count;
        push_peak300();
        start_search();
        check("t1_busy_start", bus.busy, 1);
        wait_done();
        check("t1_done",       bus.done, 1);
        check("t1_busy",       bus.busy, 0);
        check("t1_best_step",  bus.best_step, 296);
        check("t1_best_sharp", bus.best_sharp, 996);
        check("t1_step",       bus.step, 296);
        check("t1_data",       bus.vcm_data, 16'h1280);
        check("t1_writes",     hs_count - base, 34);
        check("t1_queue",      exp_q.size(), 0);

        // 2: settle frames poisoned with all-ones must never be captured.
        poison = 1'b1;
        base = hs_count;
        push_peak300();
        start_search();
        check("t2_done_cleared", bus.done, 0);
        wait_done();
        check("t2_done",       bus.done, 1);
        check("t2_best_sharp", bus.best_sharp, 996);
        check("t2_best_step",  bus.best_step, 296);
        check("t2_writes",     hs_count - base, 34);
        poison = 1'b0;

        // 3: slow ack, then ack coincident with request.
        ack_delay = 50;
        base = hs_count;
        push_peak300();
        start_search();
        wait_done();
        check("t3a_done",   bus.done, 1);
        check("t3a_writes", hs_count - base, 34);
        ack_delay = 0;
        base = hs_count;
        push_peak300();
        start_search();
        wait_done();
        check("t3b_done",   bus.done, 1);
        check("t3b_best",   bus.best_step, 296);
        check("t3b_writes", hs_count - base, 34);
        ack_delay = 1;

        // 4: metric rising toward the top of the range.
        mode = 1;
        base = hs_count;
        push_range(0, 960, 64);
        push_range(896, 1016, 8);
        exp_q.push_back(16'(1016 << 4));
        start_search();
        wait_done();
        check("t4_done",       bus.done, 1);
        check("t4_best_step",  bus.best_step, 1016);
        check("t4_best_sharp", bus.best_sharp, 1016);
        check("t4_step",       bus.step, 1016);
        check("t4_writes",     hs_count - base, 33);
        mode = 0;

        // 5a: abort in SETTLE after the move to 128.
        base = hs_count;
        push_range(0, 128, 64);
        start_search();
        wait_hs(base + 3, 500);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check("t5a_busy", bus.busy, 0);
        check("t5a_done", bus.done, 0);
        check("t5a_step", bus.step, 128);
        check("t5a_data", bus.vcm_data, 16'h0800);
        tick(30);
        check("t5a_writes", hs_count - base, 3);

        // 5b: abort in MOVE waits for the ack.
        ack_delay = 20;
        base = hs_count;
        exp_q.push_back(16'h0000);
        start_search();
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        tick(4);
        check("t5b_busy_held", bus.busy, 1);
        check("t5b_req_held",  bus.vcm_req, 1);
        wait_hs(base + 1, 200);
        check("t5b_busy", bus.busy, 0);
        check("t5b_done", bus.done, 0);
        check("t5b_req",  bus.vcm_req, 0);
        tick(40);
        check("t5b_writes", hs_count - base, 1);

        // 6: reset during the first fine move, with auto_foc held high.
        ack_delay = 30;
        base = hs_count;
        push_range(0, 960, 64);
        start_search();
        wait_hs(base + 16, 2000);
        n = 0;
        while (!bus.vcm_req && n < 200) begin
            tick(1);
            n++;
        end
        tick(3);
        check("t6_in_fine_move", bus.step, 256);
        reset = 1'b1;
        tick(1);
        check("t6_req",   bus.vcm_req, 0);
        check("t6_data",  bus.vcm_data, 0);
        check("t6_step",  bus.step, 0);
        check("t6_best",  bus.best_step, 0);
        check("t6_sharp", bus.best_sharp, 0);
        check("t6_busy",  bus.busy, 0);
        check("t6_done",  bus.done, 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        check("t6_no_restart", bus.busy, 0);
        check("t6_writes",     hs_count - base, 16);
        ack_delay = 1;
        base = hs_count;
        push_peak300();
        start_search();
        check("t6_restart_step", bus.step, 0);
        wait_done();
        check("t6_done_after", bus.done, 1);
        check("t6_best_after", bus.best_step, 296);
        check("t6_queue",      exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/focus_sweep_sched.md
Name: focus_sweep_sched

Overview:
Frame-synchronous autofocus scheduler that sequences the VCM lens actuator through a coarse and then a fine search, hill-climbing on a per-frame sharpness metric.
- Upstream: the sharpness-statistics datapath, which supplies one metric per frame.
- Downstream: the VCM I2C writer, driven through a REQ/ACK handshake.
- On completion, parks the lens at the best position found and reports it.

Parameters:
STEP_MIN, 0, lowest VCM step searched (10-bit).
STEP_MAX, 1020, highest VCM step searched (10-bit).
COARSE_STEP, 64, coarse sweep increment; also the half-width of the fine window.
FINE_STEP, 8, fine sweep increment.
SETTLE_FRAMES, 2, frame ends discarded after each VCM move before measuring (1..15).

Ports:
VIDEO_CLK  in  1  sole clock, rising edge.
RESET  in  1  synchronous, active-high reset.
AUTO_FOC  in  1  start request, level; a rising edge starts a search.
ABORT  in  1  single-cycle pulse; cancels the search.
FRAME_END  in  1  single-cycle pulse; SHARP is valid in the same cycle.
SHARP  in  24  unsigned sharpness metric of the frame just ended.
VCM_ACK  in  1  I2C writer has accepted VCM_DATA.
VCM_REQ  out  1  VCM write request.
VCM_DATA  out  16  {2'b00, STEP[9:0], 4'b0000}.
STEP  out  10  current commanded lens position.
BEST_STEP  out  10  best position found so far.
BEST_SHARP  out  24  metric measured at BEST_STEP.
BUSY  out  1  high while a search is running.
DONE  out  1  high from a successful park until the next start or reset.

Behaviour:
- Single clock; reset is synchronous, active-high, on VIDEO_CLK.
- Reset values:
  - all outputs 0, VCM_DATA = 16'h0000;
  - FSM = IDLE, abort latch cleared;
  - AUTO_FOC edge register loaded with the current AUTO_FOC, so a level held through reset does not start a search.
- Reset mid-operation: VCM_REQ drops on the next edge. The next search restarts from STEP_MIN.
- FSM states: IDLE, MOVE, SETTLE, MEASURE, ADVANCE, FINE_INIT, PARK, PARK_WAIT.
- IDLE:
  - On an AUTO_FOC rising edge, clear DONE, BEST_SHARP and BEST_STEP.
  - Set STEP = STEP_MIN, phase = COARSE, BUSY = 1; go to MOVE.
- MOVE:
  - VCM_REQ = 1, with VCM_DATA reflecting STEP; both are held stable until VCM_ACK.
  - ACK may be sampled on the first REQ cycle.
  - On ACK: VCM_REQ = 0 on the next edge, clear the settle counter, go to SETTLE.
- SETTLE: count FRAME_END pulses; after SETTLE_FRAMES of them, go to MEASURE. Metrics seen in this state are ignored.
- MEASURE:
  - On the next FRAME_END, if SHARP > BEST_SHARP (strictly greater; ties keep the earlier step), load BEST_SHARP = SHARP and BEST_STEP = STEP.
  - Go to ADVANCE.
- ADVANCE (single cycle):
  - Compute next = STEP + increment in 11 bits. The increment is COARSE_STEP or FINE_STEP according to phase.
  - If next > the phase's upper limit (STEP_MAX for coarse, HI for fine), the phase ends: coarse goes to FINE_INIT, fine goes to PARK.
  - Otherwise STEP = next; go to MOVE.
- FINE_INIT (single cycle):
  - LO = max(BEST_STEP - COARSE_STEP, STEP_MIN), computed signed with no underflow.
  - HI = min(BEST_STEP + COARSE_STEP, STEP_MAX).
  - Set STEP = LO, phase = FINE; go to MOVE.
  - BEST_SHARP and BEST_STEP are retained, so fine-phase points must strictly beat the coarse best.
- PARK: STEP = BEST_STEP; issue one MOVE handshake, then PARK_WAIT.
- PARK_WAIT: after the ACK, BUSY = 0, DONE = 1; go to IDLE.
- ABORT:
  - In IDLE: ignored.
  - In SETTLE, MEASURE, ADVANCE or FINE_INIT: go to IDLE next cycle with BUSY = 0 and DONE = 0. STEP and VCM_DATA hold their last values; no park is performed.
  - In MOVE or PARK: the abort is latched and acted on at the ACK edge, so the handshake never breaks.
- AUTO_FOC edges while BUSY are ignored.
- A FRAME_END arriving in the same cycle as a state entry counts in the new state.
- Latency: metric capture to the next VCM_REQ is 2 cycles (MEASURE → ADVANCE → MOVE).

Test Plan:
1. Defaults; SHARP = 1000 − |STEP − 300|; ACK 1 cycle after REQ.
   - Coarse visits 0, 64, …, 960 (16 moves), best 320.
   - Fine window 256..384 in steps of 8 (17 moves), best 296 (the tie with 304 keeps 296).
   - Park at 296, VCM_DATA = 16'h1280, BEST_SHARP = 996, DONE = 1, 34 handshakes in total.
2. Settle count check: 3 FRAME_END pulses per position; confirm only every third metric is captured (inject 24'hFFFFFF on settle frames; BEST_SHARP is unaffected).
3. ACK delayed 50 cycles, and ACK coincident with REQ: VCM_REQ and VCM_DATA are stable throughout; exactly one write per position.
4. Metric peak at STEP_MAX edge (SHARP = STEP):
   - Coarse best 960, fine window 896..1020.
   - Last fine point 1016, because 1024 > HI; park at 1016.
5. ABORT during SETTLE at coarse step 128: next cycle BUSY = 0, DONE = 0, STEP = 128. ABORT during MOVE: the return to IDLE waits for the ACK.
6. RESET asserted during fine MOVE: the next edge gives VCM_REQ = 0 and all outputs 0. AUTO_FOC held high through reset does not restart; a fresh rising edge starts a search from STEP_MIN.
